// File: rtl/resolution_text_streamer_pkg.sv
// Shared types, mode ids and the resolution text table
// for the OSD resolution text streamer.
package resolution_text_streamer_pkg;

  localparam int RESLINE_SIZE = 128;
  localparam int ID_W = 5;

  localparam logic [ID_W-1:0] MODE_1080p60 = 5'd0;
  localparam logic [ID_W-1:0] MODE_720p60  = 5'd1;
  localparam logic [ID_W-1:0] MODE_576i50  = 5'd2;
  localparam logic [ID_W-1:0] MODE_480i60  = 5'd3;
  localparam logic [ID_W-1:0] INVALID_MODE_ID = '1;

  localparam logic [7:0] SPACE_CHAR = 8'h20;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            interlaced;
    logic [11:0]     h_active;
    logic [11:0]     v_active;
  } VideoMode;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_READY,
    ST_STREAM
  } state_t;

  function automatic logic [95:0] mode_name(
    input logic [ID_W-1:0] id
  );
    logic [95:0] n;
    n = '0;
    unique case (id)
      MODE_1080p60: n = "1920x1080p60";
      MODE_720p60:  n = "1280x720p60 ";
      MODE_576i50:  n = "720x576i50  ";
      MODE_480i60:  n = "720x480i60  ";
      default:      n = '0;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] hex_char(
    input logic [3:0] v
  );
    if (v < 4'd10) return 8'h30 + 8'(v);
    return 8'h37 + 8'(v);
  endfunction

  // Each line reads "<mode name> L<n> "; unknown ids are blank.
  function automatic logic [RESLINE_SIZE-1:0] res_text(
    input logic [ID_W-1:0] id,
    input int              line
  );
    logic [95:0] n;
    n = mode_name(id);
    if (n == '0) return {(RESLINE_SIZE/8){SPACE_CHAR}};
    return {n, " L", hex_char(4'(line)), " "};
  endfunction

endpackage

// File: rtl/resolution_text_streamer_if.sv
// Line request and character stream handshakes between
// the text streamer and the OSD character renderer.
interface resolution_text_streamer_if #(
  parameter int ADDR_W     = 4,
  parameter int CHAR_WIDTH = 8
) ();

  logic                  req_valid;
  logic [ADDR_W:0]       req_line;
  logic                  req_ready;
  logic [CHAR_WIDTH-1:0] char_data;
  logic                  char_valid;
  logic                  char_ready;
  logic                  char_last;

  modport master (
    output req_valid,
    output req_line,
    output char_ready,
    input  req_ready,
    input  char_data,
    input  char_valid,
    input  char_last
  );

  modport slave (
    input  req_valid,
    input  req_line,
    input  char_ready,
    output req_ready,
    output char_data,
    output char_valid,
    output char_last
  );

endinterface

// File: rtl/resolution_text_streamer_rom.sv
// Registered per-mode resolution text ROM, one line per
// read with a single cycle of latency.
module resolution_rom_p
  import resolution_text_streamer_pkg::*;
#(
  parameter int LINE_SIZE = RESLINE_SIZE,
  parameter int NUM_LINES = 16,
  localparam int ADDR_W   = $clog2(NUM_LINES)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [ID_W-1:0]      i_id,
  input  logic [ADDR_W-1:0]    i_line,
  output logic [LINE_SIZE-1:0] o_data
);

  logic [RESLINE_SIZE-1:0] w_txt;
  logic [LINE_SIZE-1:0]    w_line;

  always_comb begin
    w_txt = res_text(i_id, int'(i_line));
  end

  if (LINE_SIZE <= RESLINE_SIZE) begin : g_trim
    assign w_line = w_txt[RESLINE_SIZE-1 -: LINE_SIZE];
  end else begin : g_pad
    assign w_line = {
      w_txt,
      {((LINE_SIZE - RESLINE_SIZE) / 8){SPACE_CHAR}}
    };
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      o_data <= '0;
    end else begin
      o_data <= w_line;
    end
  end

endmodule

// File: rtl/resolution_text_streamer.sv
// Caches the current mode's text lines and streams a requested
// line one character per handshake to the OSD renderer.
module resolution_text_streamer
  import resolution_text_streamer_pkg::*;
#(
  parameter int LINE_SIZE  = RESLINE_SIZE,
  parameter int CHAR_WIDTH = 8,
  parameter int NUM_LINES  = 16,
  parameter int MODE_ID_W  = 5,
  parameter logic [CHAR_WIDTH-1:0] BLANK_CHAR = 8'h20
) (
  input  logic     clock,
  input  logic     reset_n,
  input  VideoMode videoMode,
  resolution_text_streamer_if.slave bus,
  output logic     busy,
  output logic     cache_valid
);

  localparam int ADDR_W = $clog2(NUM_LINES);
  localparam int CHARS  = LINE_SIZE / CHAR_WIDTH;
  localparam int IDX_W  = (CHARS > 1) ? $clog2(CHARS) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(NUM_LINES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(CHARS - 1);
  localparam logic [ADDR_W:0] LINE_LIM =
    (ADDR_W + 1)'(NUM_LINES);
  localparam logic [LINE_SIZE-1:0] BLANK_LINE =
    {CHARS{BLANK_CHAR}};

  state_t               r_state;
  logic [MODE_ID_W-1:0] r_id_q;
  logic [MODE_ID_W-1:0] r_latched_id;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_issue;
  logic                 r_v1;
  logic [ADDR_W-1:0]    r_a1;
  logic [LINE_SIZE-1:0] r_line;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_char_valid;
  logic                 r_char_last;
  logic                 r_busy;
  logic                 r_cache_valid;
  logic                 r_ready;

  logic [LINE_SIZE-1:0] r_buf [NUM_LINES];

  logic                 w_change;
  logic                 w_hs;
  logic [LINE_SIZE-1:0] w_sel;
  logic [LINE_SIZE-1:0] w_rom_data;
  logic [ID_W-1:0]      w_rom_id;
  logic                 w_unused;

  assign w_unused = ^{
    videoMode.interlaced,
    videoMode.h_active,
    videoMode.v_active
  };

  assign w_change = (r_id_q != r_latched_id);
  assign w_hs     = r_char_valid && bus.char_ready;
  assign w_rom_id = ID_W'(r_latched_id);

  always_comb begin
    w_sel = BLANK_LINE;
    if (bus.req_line < LINE_LIM) begin
      w_sel = r_buf[bus.req_line[ADDR_W-1:0]];
    end
  end

  resolution_rom_p #(
    .LINE_SIZE (LINE_SIZE),
    .NUM_LINES (NUM_LINES)
  ) u_rom (
    .clock   (clock),
    .reset_n (reset_n),
    .i_id    (w_rom_id),
    .i_line  (r_addr),
    .o_data  (w_rom_data)
  );

  // Line storage is overwritten by every fill, so it needs no reset.
  always_ff @(posedge clock) begin
    if (r_v1) begin
      r_buf[r_a1] <= w_rom_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_id_q        <= '1;
      r_latched_id  <= '1;
      r_addr        <= '0;
      r_issue       <= 1'b0;
      r_v1          <= 1'b0;
      r_a1          <= '0;
      r_line        <= '0;
      r_idx         <= '0;
      r_char_valid  <= 1'b0;
      r_char_last   <= 1'b0;
      r_busy        <= 1'b0;
      r_cache_valid <= 1'b0;
      r_ready       <= 1'b0;
    end else begin
      r_id_q <= videoMode.id[MODE_ID_W-1:0];
      r_v1   <= r_issue;
      r_a1   <= r_addr;
      // A mode change preempts every state, including a fill.
      if (w_change) begin
        r_state       <= ST_FILL;
        r_latched_id  <= r_id_q;
        r_addr        <= '0;
        r_issue       <= 1'b1;
        r_v1          <= 1'b0;
        r_busy        <= 1'b1;
        r_cache_valid <= 1'b0;
        r_ready       <= 1'b0;
        r_char_valid  <= 1'b0;
        r_char_last   <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
          end
          ST_FILL: begin
            if (r_issue) begin
              r_addr <= r_addr + 1'b1;
              if (r_addr == LAST_ADDR) r_issue <= 1'b0;
            end
            if (r_v1 && (r_a1 == LAST_ADDR)) begin
              r_state       <= ST_READY;
              r_busy        <= 1'b0;
              r_cache_valid <= 1'b1;
              r_ready       <= 1'b1;
            end
          end
          ST_READY: begin
            if (bus.req_valid) begin
              r_line       <= w_sel;
              r_idx        <= '0;
              r_char_valid <= 1'b1;
              r_char_last  <= (CHARS == 1);
              r_ready      <= 1'b0;
              r_state      <= ST_STREAM;
            end
          end
          ST_STREAM: begin
            if (w_hs) begin
              if (r_char_last) begin
                r_char_valid <= 1'b0;
                r_char_last  <= 1'b0;
                r_ready      <= 1'b1;
                r_state      <= ST_READY;
              end else begin
                r_line      <= r_line << CHAR_WIDTH;
                r_idx       <= r_idx + 1'b1;
                r_char_last <= (r_idx == LAST_IDX - 1'b1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.req_ready  = r_ready && !w_change;
  assign bus.char_data  = r_line[LINE_SIZE-1 -: CHAR_WIDTH];
  assign bus.char_valid = r_char_valid;
  assign bus.char_last  = r_char_last;
  assign busy           = r_busy;
  assign cache_valid    = r_cache_valid;

endmodule

// File: tb/tb_resolution_text_streamer.sv
// Directed bench for resolution_text_streamer: fill timing,
// line streaming, stalls, blank lines and mode-change aborts.
module tb_resolution_text_streamer;
  import resolution_text_streamer_pkg::*;

  logic     clk;
  logic     rst_n;
  VideoMode vm;
  logic     busy;
  logic     cache_valid;

  resolution_text_streamer_if #(
    .ADDR_W     (4),
    .CHAR_WIDTH (8)
  ) bus ();

  resolution_text_streamer dut (
    .clock       (clk),
    .reset_n     (rst_n),
    .videoMode   (vm),
    .bus         (bus),
    .busy        (busy),
    .cache_valid (cache_valid)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  sb [$];
  logic [4:0]  cur_id;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_line(
    input logic [4:0] id,
    input int         ln
  );
    string nm;
    string hx;
    string s;
    logic [127:0] r;
    hx = "0123456789ABCDEF";
    case (id)
      MODE_1080p60: nm = "1920x1080p60";
      MODE_720p60:  nm = "1280x720p60 ";
      MODE_576i50:  nm = "720x576i50  ";
      MODE_480i60:  nm = "720x480i60  ";
      default:      nm = "";
    endcase
    r = {16{8'h20}};
    if (ln < 16 && nm.len() == 12) begin
      s = {nm, " L", hx.substr(ln, ln), " "};
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    end
    return r;
  endfunction

  // j counts clock edges after the edge where id_q took the new id.
  task automatic wait_cv(
    input  int j0,
    output int first,
    output bit any_valid
  );
    first = -1;
    any_valid = 1'b0;
    for (int j = j0 + 1; j <= j0 + 45; j++) begin
      @(negedge clk);
      if (bus.char_valid === 1'b1) any_valid = 1'b1;
      if (cache_valid === 1'b1) begin
        first = j;
        break;
      end
    end
  endtask

  task automatic stream(
    input  int ln,
    input  bit toggle,
    output int n_hs,
    output int n_cyc
  );
    logic [127:0] ex;
    logic [7:0]   held;
    logic [7:0]   e;
    bit           stalled;
    int           c;
    int           g;
    ex = model_line(cur_id, ln);
    bus.req_valid = 1'b1;
    bus.req_line  = 5'(ln);
    g = 0;
    while (bus.req_ready !== 1'b1 && g < 60) begin
      @(negedge clk);
      g++;
    end
    chk("req_ready", 128'(bus.req_ready), 128'(1));
    for (int i = 0; i < 16; i++) sb.push_back(ex[127-8*i -: 8]);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_hs = 0;
    n_cyc = 0;
    c = 0;
    stalled = 1'b0;
    held = '0;
    while (sb.size() > 0 && c < 100) begin
      bus.char_ready = toggle ? (c % 2 == 0) : 1'b1;
      if (bus.char_valid === 1'b1) begin
        n_cyc++;
        if (stalled) chk("stall_hold", 128'(bus.char_data), 128'(held));
        if (bus.char_ready) begin
          e = sb.pop_front();
          chk("char", 128'(bus.char_data), 128'(e));
          chk("last", 128'(bus.char_last), 128'(sb.size() == 0));
          n_hs++;
          stalled = 1'b0;
        end else begin
          held = bus.char_data;
          stalled = 1'b1;
        end
      end
      c++;
      @(negedge clk);
    end
    bus.char_ready = 1'b0;
    chk("stream_done", 128'(sb.size()), 128'(0));
    chk("req_ready_after", 128'(bus.req_ready), 128'(1));
    chk("valid_after", 128'(bus.char_valid), 128'(0));
    sb.delete();
  endtask

  initial begin
    int           nb;
    int           first;
    int           hs;
    int           cyc;
    bit           anyv;
    logic [127:0] ex;
    logic [7:0]   e;

    rst_n = 1'b0;
    vm = '0;
    vm.id = MODE_1080p60;
    cur_id = MODE_1080p60;
    bus.req_valid = 1'b0;
    bus.req_line = '0;
    bus.char_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_cache_valid", 128'(cache_valid), 128'(0));
    chk("rst_char_valid", 128'(bus.char_valid), 128'(0));
    chk("rst_req_ready", 128'(bus.req_ready), 128'(0));
    chk("rst_char_last", 128'(bus.char_last), 128'(0));
    chk("rst_char_data", 128'(bus.char_data), 128'(0));

    // First fill after reset release.
    rst_n = 1'b1;
    @(negedge clk);
    chk("fill_busy_j0", 128'(busy), 128'(0));
    nb = 0;
    first = -1;
    for (int j = 1; j <= 22; j++) begin
      @(negedge clk);
      if (busy === 1'b1) nb++;
      if (cache_valid === 1'b1 && first < 0) first = j;
    end
    chk("fill_busy_cycles", 128'(nb), 128'(17));
    chk("fill_cv_at", 128'(first), 128'(18));

    for (int l = 0; l < 16; l++) begin
      stream(l, 1'b0, hs, cyc);
      if (l == 2) begin
        chk("line2_hs", 128'(hs), 128'(16));
        chk("line2_cycles", 128'(cyc), 128'(16));
      end
    end

    stream(5, 1'b1, hs, cyc);
    chk("toggle_hs", 128'(hs), 128'(16));
    chk("toggle_cycles", 128'(cyc), 128'(31));

    stream(16, 1'b0, hs, cyc);
    chk("blank16_hs", 128'(hs), 128'(16));
    stream(31, 1'b1, hs, cyc);
    chk("blank31_hs", 128'(hs), 128'(16));

    vm.id = MODE_720p60;
    @(negedge clk);
    wait_cv(0, first, anyv);
    chk("refill720_cv_at", 128'(first), 128'(18));
    cur_id = MODE_720p60;

    // Abort a 720p60 stream after char 5 by switching to 576i50.
    bus.req_valid = 1'b1;
    bus.req_line = 5'd3;
    chk("abort_req_ready", 128'(bus.req_ready), 128'(1));
    ex = model_line(MODE_720p60, 3);
    for (int i = 0; i < 16; i++) sb.push_back(ex[127-8*i -: 8]);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.char_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e = sb.pop_front();
      chk("abort_char", 128'(bus.char_data), 128'(e));
      if (i == 5) vm.id = MODE_576i50;
      @(negedge clk);
    end
    chk("abort_detect_valid", 128'(bus.char_valid), 128'(1));
    e = sb.pop_front();
    chk("abort_detect_char", 128'(bus.char_data), 128'(e));
    @(negedge clk);
    chk("abort_valid_drop", 128'(bus.char_valid), 128'(0));
    chk("abort_no_last", 128'(bus.char_last), 128'(0));
    chk("abort_busy", 128'(busy), 128'(1));
    bus.char_ready = 1'b0;
    sb.delete();
    wait_cv(1, first, anyv);
    chk("abort_refill_cv_at", 128'(first), 128'(18));
    chk("abort_refill_quiet", 128'(anyv), 128'(0));
    cur_id = MODE_576i50;
    stream(1, 1'b0, hs, cyc);
    stream(12, 1'b0, hs, cyc);

    // Mode change together with a request, then a second change mid-fill.
    vm.id = MODE_480i60;
    bus.req_valid = 1'b1;
    bus.req_line = 5'd0;
    @(negedge clk);
    chk("collide_req_ready", 128'(bus.req_ready), 128'(0));
    bus.req_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("dbl_busy_mid", 128'(busy), 128'(1));
    vm.id = MODE_720p60;
    @(negedge clk);
    wait_cv(0, first, anyv);
    chk("dbl_cv_at", 128'(first), 128'(18));
    chk("dbl_no_stream", 128'(anyv), 128'(0));
    cur_id = MODE_720p60;
    stream(0, 1'b0, hs, cyc);
    stream(9, 1'b0, hs, cyc);
    stream(15, 1'b1, hs, cyc);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
